// File: rtl/zadajnik_obrotow.sv
// Engine speed setpoint generator: debounced buttons/switch set a target rpm, actual rpm
// ramps toward it one step at a time, and clocks-per-degree comes from a serial divider.
module zadajnik_obrotow #(
    parameter int NUM_K           = 20160,
    parameter int RPM_MIN         = 5,
    parameter int RPM_MAX         = 127,
    parameter int RPM_KROK        = 5,
    parameter int RAMP_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       przycisk_gora,
    input  logic       przycisk_dol,
    input  logic       wlacz,
    output logic [6:0] rpm,
    output logic       sygnal_zmiany_rpm,
    output logic       rozruch,
    output logic [8:0] taktowanie_na_stopien,
    output logic [1:0] stan
);
    typedef enum logic [1:0] {
        STOP      = 2'd0,
        ROZRUCH   = 2'd1,
        PRACA     = 2'd2,
        HAMOWANIE = 2'd3
    } stan_t;

    localparam int          DW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int          RW        = $clog2(RAMP_CYCLES + 1);
    localparam logic [4:0]  DIV_STEPS = 5'd20;
    localparam logic [19:0] C_NUM     = 20'(NUM_K);
    localparam logic [7:0]  C_MIN8    = 8'(RPM_MIN);
    localparam logic [7:0]  C_MAX8    = 8'(RPM_MAX);
    localparam logic [7:0]  C_KROK8   = 8'(RPM_KROK);
    localparam logic [6:0]  C_MIN7    = 7'(RPM_MIN);
    localparam logic [6:0]  C_MAX7    = 7'(RPM_MAX);
    localparam logic [6:0]  C_KROK7   = 7'(RPM_KROK);

    // Channel order: 0 = gora, 1 = dol, 2 = wlacz.
    logic [2:0]    w_raw;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_stable;
    logic [DW-1:0] r_deb_cnt [3];
    logic [2:0]    w_accept;

    assign w_raw = {wlacz, przycisk_dol, przycisk_gora};

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < 3; i++)
            w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_deb_cnt[i] <= '0;
                    r_stable[i]  <= r_sync2[i];
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    logic       w_ev_gora;
    logic       w_ev_dol;
    logic [7:0] w_up;
    logic [6:0] w_dn;
    logic [6:0] r_target;

    assign w_ev_gora = w_accept[0] & r_sync2[0];
    assign w_ev_dol  = w_accept[1] & r_sync2[1];
    assign w_up      = {1'b0, r_target} + C_KROK8;
    assign w_dn      = r_target - C_KROK7;

    // Presses accepted on the same edge cancel each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= C_MIN7;
        end else if (w_ev_gora && !w_ev_dol) begin
            r_target <= (w_up > C_MAX8) ? C_MAX7 : w_up[6:0];
        end else if (w_ev_dol && !w_ev_gora) begin
            r_target <= ({1'b0, r_target} < (C_MIN8 + C_KROK8)) ? C_MIN7 : w_dn;
        end
    end

    stan_t         r_stan;
    logic          r_rozruch;
    logic [6:0]    r_rpm;
    logic [8:0]    r_takt;
    logic          r_strobe;
    logic          r_busy;
    logic [4:0]    r_div_cnt;
    logic [19:0]   r_num;
    logic [6:0]    r_rem;
    logic [19:0]   r_quo;
    logic [6:0]    r_rpm_next;
    logic [RW-1:0] r_ramp_cnt;

    logic [6:0] w_goal;
    logic       w_ramp_ok;
    logic       w_tick;
    logic       w_publish;
    logic [6:0] w_rpm_step;
    logic [7:0] w_shift;
    logic       w_fits;
    logic [8:0] w_takt;

    assign w_goal     = (r_stan == ROZRUCH || r_stan == PRACA) ? r_target : 7'd0;
    assign w_ramp_ok  = !r_busy && (r_rpm != w_goal);
    assign w_tick     = w_ramp_ok && (r_ramp_cnt == RW'(RAMP_CYCLES));
    assign w_publish  = r_busy && (r_div_cnt == DIV_STEPS);
    assign w_rpm_step = (r_rpm < w_goal) ? r_rpm + 7'd1 : r_rpm - 7'd1;
    assign w_shift    = {r_rem, r_num[19]};
    assign w_fits     = w_shift >= {1'b0, r_rpm_next};
    assign w_takt     = (r_quo > 20'd511) ? 9'd511 : r_quo[8:0];

    // sygnal_zmiany_rpm is a one-cycle valid with no ready: rpm and taktowanie_na_stopien
    // change only in the cycle it is high and are stable whenever it is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stan     <= STOP;
            r_rozruch  <= 1'b0;
            r_rpm      <= '0;
            r_takt     <= '0;
            r_strobe   <= 1'b0;
            r_busy     <= 1'b0;
            r_div_cnt  <= '0;
            r_num      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_rpm_next <= '0;
            r_ramp_cnt <= '0;
        end else begin
            r_strobe <= 1'b0;
            if (r_busy) begin
                if (w_publish) begin
                    r_busy   <= 1'b0;
                    r_rpm    <= r_rpm_next;
                    r_takt   <= w_takt;
                    r_strobe <= 1'b1;
                end else begin
                    r_rem     <= 7'(w_fits ? (w_shift - {1'b0, r_rpm_next}) : w_shift);
                    r_num     <= {r_num[18:0], 1'b0};
                    r_quo     <= {r_quo[18:0], w_fits};
                    r_div_cnt <= r_div_cnt + 5'd1;
                end
            end else if (w_tick) begin
                // A step to zero skips the division and publishes on the next edge.
                r_busy     <= 1'b1;
                r_rpm_next <= w_rpm_step;
                r_num      <= C_NUM;
                r_rem      <= '0;
                r_quo      <= '0;
                r_div_cnt  <= (w_rpm_step == 7'd0) ? DIV_STEPS : 5'd0;
                r_ramp_cnt <= '0;
            end else if (w_ramp_ok) begin
                r_ramp_cnt <= r_ramp_cnt + RW'(1);
            end else begin
                r_ramp_cnt <= '0;
            end

            case (r_stan)
                STOP: begin
                    if (r_stable[2]) begin
                        r_stan    <= ROZRUCH;
                        r_rozruch <= 1'b1;
                    end
                end
                ROZRUCH: begin
                    if (!r_stable[2])                          r_stan <= HAMOWANIE;
                    else if (!r_busy && (r_rpm == r_target))   r_stan <= PRACA;
                end
                PRACA: begin
                    if (!r_stable[2]) r_stan <= HAMOWANIE;
                end
                HAMOWANIE: begin
                    if (r_stable[2]) begin
                        r_stan <= ROZRUCH;
                    end else if ((w_publish && r_rpm_next == 7'd0) || (!r_busy && r_rpm == 7'd0)) begin
                        r_stan    <= STOP;
                        r_rozruch <= 1'b0;
                    end
                end
                default: r_stan <= STOP;
            endcase
        end
    end

    assign rpm                   = r_rpm;
    assign sygnal_zmiany_rpm     = r_strobe;
    assign rozruch               = r_rozruch;
    assign taktowanie_na_stopien = r_takt;
    assign stan                  = r_stan;
endmodule
